uart_rx_ctrl: RTL and testbench
===============================

# uart_rx_ctrl

Frame sequencer and result buffer for the UART receiver. Holds a shadow copy of the frame configuration and applies it only between frames. Arms the receiver through `rx_start` and captures each completed frame with its error status into a small FIFO. The host drains the FIFO through a valid/ready handshake; the block also keeps a saturating error counter and a sticky overflow flag.

## Interface

**Parameters**
- `FIFO_DEPTH`, default 4: number of frame entries; power of two, ≥2.
- `ERR_CNT_W`, default 8: width of the error counter.

**Ports**
- `rx_clk` in 1: single clock; the receiver runs on the same clock.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: enables arming of new frames.
- `cfg_wr` in 1: writes the shadow configuration from the `cfg_*` inputs.
- `cfg_length` in 4: data bits per frame; legal values 5–8.
- `cfg_parity_type` in 1: 1 = odd, 0 = even, per the receiver's convention.
- `cfg_parity_en` in 1: parity bit present.
- `cfg_stop2` in 1: two stop bits.
- `rx_start` out 1: arm to the receiver.
- `length` out 4: live configuration to the receiver.
- `parity_type` out 1: live configuration to the receiver.
- `parity_en` out 1: live configuration to the receiver.
- `stop2` out 1: live configuration to the receiver.
- `rx_out` in 8: received data from the receiver; stable when `rx_done`=1.
- `rx_done` in 1: one-cycle frame-complete pulse from the receiver.
- `rx_err` in 1: receiver error; may pulse in any cycle of a frame.
- `dout` out 8: head FIFO entry data.
- `dout_err` out 1: head FIFO entry error flag.
- `dout_valid` out 1: FIFO not empty.
- `dout_ready` in 1: host accepts the head entry.
- `err_cnt` out `ERR_CNT_W`: count of errored frames.
- `err_clr` in 1: clears `err_cnt`.
- `ovf` out 1: sticky flag; a frame was dropped because the FIFO was full.
- `ovf_clr` in 1: clears `ovf`.
- `busy` out 1: 1 in any state other than IDLE.

## Operation

**States**
- **IDLE:** `rx_start`=0. Goes to ARM when `en`=1.
- **ARM:** one cycle. Copies the shadow configuration to the live outputs and clears `err_seen`. Goes to WAIT.
- **WAIT:** `rx_start`=1.
  - Sets `err_seen` whenever `rx_err`=1.
  - On `rx_done`=1, latches `rx_out` and `err_seen|rx_err` into the capture register, then goes to CAPTURE.
  - Deasserting `en` in WAIT does not abort: the block stays in WAIT until `rx_done`.
- **CAPTURE:** `rx_start`=0.
  - Pushes the capture register into the FIFO; if the error flag is set, increments `err_cnt`.
  - Goes to ARM if `en`=1, otherwise to IDLE.

**Configuration**
- A `cfg_wr` pulse in any state updates only the shadow register; the live outputs change only in ARM.
- A `cfg_length` outside 5..8 is stored as 8.
- When `cfg_wr` coincides with ARM, the new value is written to the shadow and the live outputs take the old shadow value.

**FIFO**
- Entry format is {err, data[7:0]}.
- A pop occurs when `dout_valid & dout_ready`.
- Push when full: the frame is dropped, `ovf` is set, and `err_cnt` still counts the frame if it is errored.
- Push and pop in the same cycle while full: the pop takes effect first and the push is accepted.
- Pointers wrap modulo `FIFO_DEPTH`.

**Counter and flags**
- `err_cnt` saturates at 2^`ERR_CNT_W`−1.
- `err_clr` coinciding with an increment: the clear wins and `err_cnt`=0.
- `ovf_clr` coinciding with a new overflow: the set wins.

## Timing

- **Reset values:**
  - State IDLE.
  - `rx_start`, `dout_valid`, `dout`, `dout_err`, `ovf`, `busy` = 0; `err_cnt` = 0.
  - Shadow and live configuration: `length`=8, `parity_type`=0, `parity_en`=0, `stop2`=0.
  - FIFO emptied.
- **Reset mid-frame:** reset forces IDLE on the next edge and discards the capture register and all FIFO contents.
- **From `en` rising (state IDLE):** ARM is the next cycle; `rx_start`=1 from the second cycle after `en` is sampled.
- **Frame capture:** with `rx_done` in cycle N:
  - CAPTURE in N+1.
  - `dout_valid` rises in N+2 when the FIFO was empty.
  - ARM in N+2 and `rx_start`=1 again in N+3.
  - Latency from `rx_done` to visible data is 2 cycles.
- **Re-arm gap:** `rx_start` is low for 2 cycles between frames, well inside half a 16-cycle bit period.
- **Outputs:** `dout`, `dout_err`, and `dout_valid` are registered. `dout` holds its value while `dout_valid`=1 and `dout_ready`=0.

## Configuration

- **Macro `UART_RX_CTRL_DROP_ERR_EN`.**
- **Defined:** frames whose captured error flag is 1 are not pushed. They still increment `err_cnt`, and they never set `ovf`.
- **Undefined:** every frame is pushed, with `dout_err` carrying its error status.

## Test plan

- **Basic receive:** reset, `cfg_wr` with length=8, no parity, `en`=1, then a receiver frame with byte 0xA5 and no error → `dout`=0xA5, `dout_err`=0, `dout_valid` 2 cycles after `rx_done`, `err_cnt`=0.
- **Config applied between frames:** `cfg_wr` length=5, parity_en=1, stop2=1 issued while in WAIT → live outputs hold 8/0/0 until `rx_done`, then change in the ARM cycle; `cfg_length`=12 → `length`=8.
- **Error path:** `rx_err` pulsed mid-frame, then `rx_done` with 0x3C → `err_cnt`=1. Without the macro, the entry is 0x3C with `dout_err`=1; with the macro, the FIFO stays empty. Repeat 256 times with `ERR_CNT_W`=8 → `err_cnt` saturates at 255.
- **Overflow:** `dout_ready`=0 and 5 frames 0x01..0x05 with `FIFO_DEPTH`=4 → FIFO holds 0x01..0x04 and `ovf`=1. Next, `dout_ready`=1 on a full FIFO in the CAPTURE cycle → pop and push both succeed.
- **Disable and reset:** `en`=0 in WAIT → frame completes, is captured, and state returns to IDLE with `rx_start`=0. `rst` asserted in WAIT with 2 entries queued → next cycle `dout_valid`=0, `busy`=0, `length`=8.

Source files
------------

// File: rtl/uart_rx_ctrl_if.sv
// -----------------------------------------------------------------------------
// uart_rx_ctrl_if
// Host-side drain handshake of the UART receive controller.
//   dout       : head FIFO entry data
//   dout_err   : head FIFO entry error flag
//   dout_valid : FIFO not empty
//   dout_ready : host accepts the head entry (pop when valid & ready)
// master = controller (drives data), slave = host (drives ready).
// -----------------------------------------------------------------------------
interface uart_rx_ctrl_if;
  logic [7:0] dout;
  logic       dout_err;
  logic       dout_valid;
  logic       dout_ready;

  modport master (
    output dout,
    output dout_err,
    output dout_valid,
    input  dout_ready
  );

  modport slave (
    input  dout,
    input  dout_err,
    input  dout_valid,
    output dout_ready
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_rx_ctrl
// Frame sequencer and result buffer for the UART receiver.
//   - Keeps a shadow frame configuration, copied to the live outputs only in
//     ARM, i.e. between frames.
//   - Arms the receiver (rx_start), captures each frame with its error status
//     and pushes it into a FIFO drained through dout_if (valid/ready).
//   - Saturating errored-frame counter (err_cnt) and sticky overflow (ovf).
//
// Ports
//   rx_clk, rst                 : clock, synchronous active-high reset
//   en                          : allow arming of new frames
//   cfg_wr, cfg_*               : shadow configuration write
//   rx_start, length, parity_*,
//   stop2                       : arm and live configuration to the receiver
//   rx_out, rx_done, rx_err     : receiver results
//   dout_if (master)            : FIFO head {dout_err, dout}, valid/ready
//   err_cnt, err_clr            : errored-frame counter and its clear
//   ovf, ovf_clr                : sticky dropped-frame flag and its clear
//   busy                        : state is not IDLE
//
// Build option
//   UART_RX_CTRL_DROP_ERR_EN : when defined, errored frames are counted but
//                              never pushed (and so never cause ovf).
//
// FIFO_DEPTH must be a power of two (pointers wrap naturally), >= 2.
// -----------------------------------------------------------------------------
module uart_rx_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                 rx_clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 cfg_wr,
  input  logic [3:0]           cfg_length,
  input  logic                 cfg_parity_type,
  input  logic                 cfg_parity_en,
  input  logic                 cfg_stop2,
  output logic                 rx_start,
  output logic [3:0]           length,
  output logic                 parity_type,
  output logic                 parity_en,
  output logic                 stop2,
  input  logic [7:0]           rx_out,
  input  logic                 rx_done,
  input  logic                 rx_err,
  uart_rx_ctrl_if.master       dout_if,
  output logic [ERR_CNT_W-1:0] err_cnt,
  input  logic                 err_clr,
  output logic                 ovf,
  input  logic                 ovf_clr,
  output logic                 busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ARM     = 2'd1;
  localparam logic [1:0] S_WAIT    = 2'd2;
  localparam logic [1:0] S_CAPTURE = 2'd3;

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  logic [1:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (en) state_d = S_ARM;
      S_ARM:     state_d = S_WAIT;
      S_WAIT:    if (rx_done) state_d = S_CAPTURE;  // en low does not abort
      S_CAPTURE: state_d = en ? S_ARM : S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge rx_clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  assign rx_start = (state_q == S_WAIT);
  assign busy     = (state_q != S_IDLE);

  // ---------------------------------------------------------------------------
  // Shadow and live configuration
  // ---------------------------------------------------------------------------
  logic [3:0] cfg_len_fix;
  logic [3:0] sh_length_q;
  logic       sh_ptype_q, sh_pen_q, sh_stop2_q;
  logic [3:0] lv_length_q;
  logic       lv_ptype_q, lv_pen_q, lv_stop2_q;

  // Illegal frame lengths fall back to 8 data bits.
  assign cfg_len_fix = (cfg_length >= 4'd5 && cfg_length <= 4'd8) ? cfg_length : 4'd8;

  always_ff @(posedge rx_clk) begin
    if (rst) begin
      sh_length_q <= 4'd8;
      sh_ptype_q  <= 1'b0;
      sh_pen_q    <= 1'b0;
      sh_stop2_q  <= 1'b0;
      lv_length_q <= 4'd8;
      lv_ptype_q  <= 1'b0;
      lv_pen_q    <= 1'b0;
      lv_stop2_q  <= 1'b0;
    end else begin
      if (cfg_wr) begin
        sh_length_q <= cfg_len_fix;
        sh_ptype_q  <= cfg_parity_type;
        sh_pen_q    <= cfg_parity_en;
        sh_stop2_q  <= cfg_stop2;
      end
      // Reads the pre-write shadow, so a cfg_wr in ARM lands in the next frame.
      if (state_q == S_ARM) begin
        lv_length_q <= sh_length_q;
        lv_ptype_q  <= sh_ptype_q;
        lv_pen_q    <= sh_pen_q;
        lv_stop2_q  <= sh_stop2_q;
      end
    end
  end

  assign length      = lv_length_q;
  assign parity_type = lv_ptype_q;
  assign parity_en   = lv_pen_q;
  assign stop2       = lv_stop2_q;

  // ---------------------------------------------------------------------------
  // Error tracking and capture register
  // ---------------------------------------------------------------------------
  logic       err_seen_q;
  logic [7:0] cap_data_q;
  logic       cap_err_q;

  always_ff @(posedge rx_clk) begin
    if (rst) begin
      err_seen_q <= 1'b0;
      cap_data_q <= 8'd0;
      cap_err_q  <= 1'b0;
    end else begin
      if (state_q == S_ARM) begin
        err_seen_q <= 1'b0;
      end else if (state_q == S_WAIT && rx_err) begin
        err_seen_q <= 1'b1;
      end
      if (state_q == S_WAIT && rx_done) begin
        cap_data_q <= rx_out;
        cap_err_q  <= err_seen_q | rx_err;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Result FIFO with registered head
  // ---------------------------------------------------------------------------
  logic [8:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_nxt;
  logic [CNT_W-1:0] count_q, count_d;
  logic [8:0]       head_q, head_d;
  logic             valid_q;
  logic             capture, push_req, full, pop, push, ovf_set;
  logic [8:0]       cap_entry;

  assign capture   = (state_q == S_CAPTURE);
  assign cap_entry = {cap_err_q, cap_data_q};

`ifdef UART_RX_CTRL_DROP_ERR_EN
  assign push_req = capture & ~cap_err_q;
`else
  assign push_req = capture;
`endif

  assign full       = (count_q == CNT_W'(FIFO_DEPTH));
  assign pop        = valid_q & dout_if.dout_ready;
  // A pop in the same cycle frees the slot the push needs.
  assign push       = push_req & (~full | pop);
  assign ovf_set    = push_req & full & ~pop;
  assign rd_ptr_nxt = rd_ptr_q + PTR_W'(1);
  assign count_d    = count_q + CNT_W'(push) - CNT_W'(pop);

  // Next head: the entry behind the current one after a pop, or the pushed
  // frame when it lands in an otherwise empty FIFO.
  always_comb begin
    head_d = head_q;
    if (pop) begin
      if (count_q > CNT_W'(1)) head_d = mem[rd_ptr_nxt];
      else if (push)           head_d = cap_entry;
    end else if (count_q == '0 && push) begin
      head_d = cap_entry;
    end
  end

  always_ff @(posedge rx_clk) begin
    if (push) mem[wr_ptr_q] <= cap_entry;
  end

  always_ff @(posedge rx_clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_nxt;
      count_q <= count_d;
      head_q  <= head_d;
      valid_q <= (count_d != '0);
    end
  end

  assign dout_if.dout       = head_q[7:0];
  assign dout_if.dout_err   = head_q[8];
  assign dout_if.dout_valid = valid_q;

  // ---------------------------------------------------------------------------
  // Error counter and overflow flag
  // ---------------------------------------------------------------------------
  logic [ERR_CNT_W-1:0] err_cnt_q;
  logic                 ovf_q;

  always_ff @(posedge rx_clk) begin
    if (rst) begin
      err_cnt_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      // Dropped frames are still counted; clear beats increment.
      if (err_clr)
        err_cnt_q <= '0;
      else if (capture && cap_err_q && err_cnt_q != '1)
        err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
      // A new overflow beats a simultaneous clear.
      if (ovf_set)      ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;
    end
  end

  assign err_cnt = err_cnt_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_ctrl
// Randomized bench for uart_rx_ctrl. A transaction-level model (queue FIFO,
// integer counter, shadow/live configuration words) predicts every output.
// -----------------------------------------------------------------------------
module tb_uart_rx_ctrl;
  localparam int DEPTH = 4;
  localparam int EW    = 8;
  localparam int CMAX  = (1 << EW) - 1;
`ifdef UART_RX_CTRL_DROP_ERR_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  logic          rx_clk = 1'b0;
  logic          rst, en, cfg_wr;
  logic [3:0]    cfg_length;
  logic          cfg_parity_type, cfg_parity_en, cfg_stop2;
  logic          rx_start;
  logic [3:0]    length;
  logic          parity_type, parity_en, stop2;
  logic [7:0]    rx_out;
  logic          rx_done, rx_err;
  logic [EW-1:0] err_cnt;
  logic          err_clr, ovf, ovf_clr, busy;

  uart_rx_ctrl_if dif ();

  uart_rx_ctrl #(.FIFO_DEPTH(DEPTH), .ERR_CNT_W(EW)) dut (
    .rx_clk(rx_clk), .rst(rst), .en(en), .cfg_wr(cfg_wr),
    .cfg_length(cfg_length), .cfg_parity_type(cfg_parity_type),
    .cfg_parity_en(cfg_parity_en), .cfg_stop2(cfg_stop2),
    .rx_start(rx_start), .length(length), .parity_type(parity_type),
    .parity_en(parity_en), .stop2(stop2), .rx_out(rx_out),
    .rx_done(rx_done), .rx_err(rx_err), .dout_if(dif),
    .err_cnt(err_cnt), .err_clr(err_clr), .ovf(ovf), .ovf_clr(ovf_clr),
    .busy(busy)
  );

  always #5 rx_clk = ~rx_clk;

  // Reference model state
  logic [8:0] q[$];      // {err, data}
  int         cnt_m;
  bit         ovf_m;
  logic [6:0] shadow_m;  // {length, parity_type, parity_en, stop2}
  logic [6:0] live_m;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge rx_clk);
    #1;
  endtask

  function automatic logic [6:0] cfg_word(input logic [3:0] l, input logic pt, input logic pe, input logic s2);
    logic [3:0] lf;
    lf = (l >= 5 && l <= 8) ? l : 4'd8;
    return {lf, pt, pe, s2};
  endfunction

  function automatic logic [6:0] live_obs();
    return {length, parity_type, parity_en, stop2};
  endfunction

  task automatic model_reset();
    q.delete();
    cnt_m    = 0;
    ovf_m    = 1'b0;
    shadow_m = {4'd8, 3'b000};
    live_m   = {4'd8, 3'b000};
  endtask

  // Drives a cfg_wr for the coming edge; caller ticks and drops cfg_wr.
  task automatic cfg_drive(input logic [3:0] l, input logic pt, input logic pe, input logic s2);
    cfg_length = l; cfg_parity_type = pt; cfg_parity_en = pe; cfg_stop2 = s2;
    cfg_wr     = 1'b1;
    shadow_m   = cfg_word(l, pt, pe, s2);
  endtask

  task automatic check_head(input string tag);
    check({tag, "_valid"}, dif.dout_valid, q.size() != 0);
    if (q.size() != 0) begin
      check({tag, "_data"}, dif.dout, q[0][7:0]);
      check({tag, "_err"}, dif.dout_err, q[0][8]);
    end
  endtask

  task automatic enable_from_idle();
    en = 1'b1;
    tick();                         // ARM
    check("arm_busy", busy, 1);
    check("arm_start", rx_start, 0);
    live_m = shadow_m;
    tick();                         // WAIT
    check("arm_start_hi", rx_start, 1);
    check("arm_live", live_obs(), live_m);
  endtask

  task automatic wait_start();
    int k = 0;
    while (rx_start !== 1'b1 && k < 50) begin
      tick();
      k++;
    end
    if (rx_start !== 1'b1) check("start_timeout", 0, 1);
  endtask

  task automatic pop_one();
    check_head("pop_pre");
    dif.dout_ready = 1'b1;
    tick();
    dif.dout_ready = 1'b0;
    void'(q.pop_front());
    check_head("pop_post");
  endtask

  task automatic drain();
    while (q.size() != 0) pop_one();
  endtask

  // fl: [0] cfg_wr in ARM, [1] err_clr in CAPTURE, [2] ovf_clr in CAPTURE,
  //     [3] dout_ready in CAPTURE, [4] drop en in WAIT, [5] cfg_wr in WAIT
  task automatic send_frame(input logic [7:0] data, input int err_mode, input logic [5:0] fl);
    bit e, ovf_new;
    int gap;
    wait_start();
    if (fl[5]) begin
      cfg_drive(4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom), 1'($urandom));
      tick();
      cfg_wr = 1'b0;
      check("wait_live_hold", live_obs(), live_m);
    end
    if (fl[4]) en = 1'b0;
    if (err_mode == 1) begin
      rx_err = 1'b1;
      tick();
      rx_err = 1'b0;
    end
    gap = $urandom_range(0, 3);
    repeat (gap) tick();
    rx_out  = data;
    rx_done = 1'b1;
    rx_err  = (err_mode == 2);
    e       = (err_mode != 0);
    tick();                         // N+1: CAPTURE
    rx_done = 1'b0;
    rx_err  = 1'b0;
    rx_out  = 8'($urandom);
    check("cap_busy", busy, 1);
    check("cap_start", rx_start, 0);
    check("cap_live", live_obs(), live_m);
    check_head("cap");
    err_clr        = fl[1];
    ovf_clr        = fl[2];
    dif.dout_ready = fl[3];
    // Model: pop first, then push or drop.
    ovf_new = 1'b0;
    if (fl[3] && q.size() != 0) void'(q.pop_front());
    if (!(DROP && e)) begin
      if (q.size() < DEPTH) q.push_back({e, data});
      else ovf_new = 1'b1;
    end
    if (e && cnt_m < CMAX) cnt_m++;
    if (fl[1]) cnt_m = 0;
    ovf_m = ovf_new | (ovf_m & ~fl[2]);
    tick();                         // N+2: ARM or IDLE
    err_clr        = 1'b0;
    ovf_clr        = 1'b0;
    dif.dout_ready = 1'b0;
    check_head("head");
    check("err_cnt", err_cnt, cnt_m);
    check("ovf", ovf, ovf_m);
    check("post_busy", busy, en);
    check("post_start", rx_start, 0);
    if (en) begin
      live_m = shadow_m;
      if (fl[0]) cfg_drive(4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom), 1'($urandom));
    end
    tick();                         // N+3
    cfg_wr = 1'b0;
    check("rearm_start", rx_start, en);
    check("rearm_live", live_obs(), live_m);
    $display("frame data=%02h err=%0d queued=%0d err_cnt=%0d ovf=%0d", data, e, q.size(), cnt_m, ovf_m);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b0; cfg_wr = 1'b0; cfg_length = 4'd8;
    cfg_parity_type = 1'b0; cfg_parity_en = 1'b0; cfg_stop2 = 1'b0;
    rx_out = 8'd0; rx_done = 1'b0; rx_err = 1'b0;
    err_clr = 1'b0; ovf_clr = 1'b0; dif.dout_ready = 1'b0;
    model_reset();
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state
    check("rst_start", rx_start, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", dif.dout_valid, 0);
    check("rst_dout", dif.dout, 0);
    check("rst_dout_err", dif.dout_err, 0);
    check("rst_ovf", ovf, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_live", live_obs(), {4'd8, 3'b000});

    // Basic receive
    cfg_drive(4'd8, 1'b0, 1'b0, 1'b0);
    tick();
    cfg_wr = 1'b0;
    enable_from_idle();
    send_frame(8'hA5, 0, 6'b0);
    pop_one();

    // Configuration written mid-frame takes effect only in the next ARM
    cfg_drive(4'd5, 1'b0, 1'b1, 1'b1);
    tick();
    cfg_wr = 1'b0;
    check("cfg_hold_len", length, 8);
    send_frame(8'h11, 0, 6'b0);
    check("cfg_new_live", live_obs(), {4'd5, 3'b011});
    pop_one();
    cfg_drive(4'd12, 1'b1, 1'b1, 1'b0);
    tick();
    cfg_wr = 1'b0;
    send_frame(8'h22, 0, 6'b0);
    check("cfg_len_clamp", length, 8);
    pop_one();
    send_frame(8'h33, 0, 6'b000001);  // cfg_wr coinciding with ARM
    send_frame(8'h44, 0, 6'b0);
    drain();

    // Error path and saturation
    send_frame(8'h3C, 1, 6'b0);
    check("err_one", err_cnt, 1);
    drain();
    for (int i = 0; i < 256; i++) send_frame(8'($urandom), 1 + (i % 2), 6'b0);
    check("err_sat", err_cnt, CMAX);
    drain();
    send_frame(8'h55, 2, 6'b000010);  // clear beats increment
    check("err_clr_wins", err_cnt, 0);
    drain();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    ovf_m   = 1'b0;
    check("ovf_clr", ovf, 0);

    // Overflow
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 0, 6'b0);
    check("ovf_set", ovf, 1);
    send_frame(8'h06, 0, 6'b001000);  // pop and push while full
    send_frame(8'h07, 0, 6'b000100);  // set beats clear
    drain();

    // Disable in WAIT: frame still completes, then IDLE
    send_frame(8'h77, 0, 6'b010000);
    check("dis_idle_start", rx_start, 0);
    drain();

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      logic [5:0] fl;
      if (!en) enable_from_idle();
      fl = {($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0), 1'($urandom),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0), 1'($urandom)};
      send_frame(8'($urandom), $urandom_range(0, 2), fl);
      repeat ($urandom_range(0, 2)) if (q.size() != 0) pop_one();
    end

    // Reset mid-frame with two entries queued
    if (!en) enable_from_idle();
    drain();
    send_frame(8'hC1, 0, 6'b0);
    send_frame(8'hC2, 0, 6'b0);
    wait_start();
    rst = 1'b1;
    en  = 1'b0;
    tick();
    check("mrst_valid", dif.dout_valid, 0);
    check("mrst_busy", busy, 0);
    check("mrst_length", length, 8);
    rst = 1'b0;
    model_reset();
    tick();
    check("mrst_err_cnt", err_cnt, cnt_m);
    check("mrst_ovf", ovf, ovf_m);
    check("mrst_start", rx_start, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
